// File: rtl/pciecfg_rsp_tx.sv
// PCIe config-read response transmitter: pops completed config records from an
// FWFT FIFO and emits each one as a two-beat 64-bit AXI-Stream frame.
package pciecfg_pkg;

    localparam logic [3:0] OP_RD = 4'h1;
    localparam logic [3:0] OP_WR = 4'h2;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [9:0]  dwaddr;
        logic [3:0]  byte_mask;
        logic [31:0] data;
    } fifo_pciecfg_t;

endpackage

module pciecfg_rsp_tx
    import pciecfg_pkg::*;
#(
    parameter logic [15:0] MAGIC    = 16'h4346,
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_en,
    output logic          fifo_pciecfg_o_rd_en,
    input  logic          fifo_pciecfg_o_empty,
    input  fifo_pciecfg_t fifo_pciecfg_o_dout,
    output logic [63:0]   tx_tdata,
    output logic [7:0]    tx_tkeep,
    output logic          tx_tvalid,
    output logic          tx_tlast,
    input  logic          tx_tready,
    output logic [31:0]   stat_tx_frames,
    output logic          busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_POP  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_DAT  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    logic [2:0]    state_r;
    logic [2:0]    state_next_s;
    fifo_pciecfg_t hold_r;
    logic [15:0]   seq_r;

    function automatic logic [63:0] pack_hdr(input logic [15:0] seq, input fifo_pciecfg_t rec);
        pack_hdr = {seq, MAGIC, 4'h0, rec.opcode, 4'h0, rec.byte_mask, 6'h00, rec.dwaddr};
    endfunction

    function automatic logic [63:0] pack_dat(input fifo_pciecfg_t rec);
        pack_dat = {32'h0000_0000, rec.data};
    endfunction

    // Next-state decode; HDR/DAT only advance on a completed handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_en && !fifo_pciecfg_o_empty) begin
                    state_next_s = ST_POP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_POP: state_next_s = ST_HDR;
            ST_HDR: begin
                if (tx_tready) begin
                    state_next_s = ST_DAT;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_DAT: begin
                if (tx_tready) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_DAT;
                end
            end
            ST_GAP:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Frame sequencer, output beat registers, sequence number and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r              <= ST_IDLE;
            hold_r               <= '0;
            seq_r                <= SEQ_INIT;
            fifo_pciecfg_o_rd_en <= 1'b0;
            tx_tdata             <= 64'h0;
            tx_tkeep             <= 8'h00;
            tx_tvalid            <= 1'b0;
            tx_tlast             <= 1'b0;
            stat_tx_frames       <= 32'h0;
            busy                 <= 1'b0;
        end else begin
            state_r              <= state_next_s;
            busy                 <= (state_next_s != ST_IDLE);
            fifo_pciecfg_o_rd_en <= (state_r == ST_IDLE) && (state_next_s == ST_POP);
            case (state_r)
                ST_IDLE: begin
                    // FWFT head is valid now; capture it before the pop lands.
                    if (state_next_s == ST_POP) begin
                        hold_r <= fifo_pciecfg_o_dout;
                    end
                end
                ST_POP: begin
                    tx_tdata  <= pack_hdr(seq_r, hold_r);
                    tx_tkeep  <= 8'hFF;
                    tx_tlast  <= 1'b0;
                    tx_tvalid <= 1'b1;
                end
                ST_HDR: begin
                    if (tx_tready) begin
                        tx_tdata <= pack_dat(hold_r);
                        tx_tkeep <= 8'h0F;
                        tx_tlast <= 1'b1;
                    end
                end
                ST_DAT: begin
                    if (tx_tready) begin
                        tx_tvalid      <= 1'b0;
                        tx_tlast       <= 1'b0;
                        seq_r          <= seq_r + 16'd1;
                        stat_tx_frames <= stat_tx_frames + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pciecfg_rsp_tx.sv
// Directed bench for pciecfg_rsp_tx: FWFT FIFO models feed two instances
// (default SEQ_INIT and SEQ_INIT = FFFE); beats are captured on the falling edge.
module tb_pciecfg_rsp_tx;
    import pciecfg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_en;
    logic tready;

    logic          rd_en_a, empty_a, tvalid_a, tlast_a, busy_a;
    fifo_pciecfg_t dout_a;
    logic [63:0]   tdata_a;
    logic [7:0]    tkeep_a;
    logic [31:0]   stat_a;

    logic          rd_en_b, empty_b, tvalid_b, tlast_b, busy_b;
    fifo_pciecfg_t dout_b;
    logic [63:0]   tdata_b;
    logic [7:0]    tkeep_b;
    logic [31:0]   stat_b;

    fifo_pciecfg_t mem_a [0:15];
    fifo_pciecfg_t mem_b [0:15];
    int wr_a = 0;
    int wr_b = 0;
    int rd_a = 0;
    int rd_b = 0;
    int pop_err = 0;
    int cyc = 0;

    logic [63:0] cap_data [0:63];
    logic [7:0]  cap_keep [0:63];
    logic        cap_last [0:63];
    int          cap_cyc  [0:63];
    int          cap_n = 0;
    logic [15:0] capb_seq [0:15];
    int          capb_n = 0;

    int n_cmp = 0;
    int n_mis = 0;

    assign empty_a = (rd_a == wr_a);
    assign empty_b = (rd_b == wr_b);
    assign dout_a  = mem_a[rd_a[3:0]];
    assign dout_b  = mem_b[rd_b[3:0]];

    pciecfg_rsp_tx #(.MAGIC(16'h4346), .SEQ_INIT(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
        .fifo_pciecfg_o_rd_en(rd_en_a), .fifo_pciecfg_o_empty(empty_a),
        .fifo_pciecfg_o_dout(dout_a),
        .tx_tdata(tdata_a), .tx_tkeep(tkeep_a), .tx_tvalid(tvalid_a),
        .tx_tlast(tlast_a), .tx_tready(tready),
        .stat_tx_frames(stat_a), .busy(busy_a)
    );

    pciecfg_rsp_tx #(.MAGIC(16'h4346), .SEQ_INIT(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
        .fifo_pciecfg_o_rd_en(rd_en_b), .fifo_pciecfg_o_empty(empty_b),
        .fifo_pciecfg_o_dout(dout_b),
        .tx_tdata(tdata_b), .tx_tkeep(tkeep_b), .tx_tvalid(tvalid_b),
        .tx_tlast(tlast_b), .tx_tready(tready),
        .stat_tx_frames(stat_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en_a) begin
            if (rd_a == wr_a) pop_err <= pop_err + 1;
            else rd_a <= rd_a + 1;
        end
        if (rd_en_b) begin
            if (rd_b == wr_b) pop_err <= pop_err + 1;
            else rd_b <= rd_b + 1;
        end
    end

    always @(negedge clk) begin
        if (tvalid_a && tready && cap_n < 64) begin
            cap_data[cap_n] <= tdata_a;
            cap_keep[cap_n] <= tkeep_a;
            cap_last[cap_n] <= tlast_a;
            cap_cyc[cap_n]  <= cyc;
            cap_n           <= cap_n + 1;
        end
        if (tvalid_b && tready && !tlast_b && capb_n < 16) begin
            capb_seq[capb_n] <= tdata_b[63:48];
            capb_n           <= capb_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [9:0] dwaddr, input logic [3:0] mask, input logic [31:0] data);
        mem_a[wr_a[3:0]] = '{opcode: OP_RD, dwaddr: dwaddr, byte_mask: mask, data: data};
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [9:0] dwaddr, input logic [3:0] mask, input logic [31:0] data);
        mem_b[wr_b[3:0]] = '{opcode: OP_RD, dwaddr: dwaddr, byte_mask: mask, data: data};
        wr_b = wr_b + 1;
    endtask

    task automatic wait_frames_a(input logic [31:0] n);
        int k;
        k = 0;
        while (stat_a != n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_frames_a", stat_a, n);
        @(negedge clk);
    endtask

    task automatic wait_tvalid_a();
        int k;
        k = 0;
        while (!tvalid_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_tvalid_a", tvalid_a, 1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int p0;
        int c0;
        int k;
        rst_n  = 1'b0;
        tx_en  = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_tvalid", tvalid_a, 0);
        check_eq("rst_tlast", tlast_a, 0);
        check_eq("rst_tdata", tdata_a, 64'h0);
        check_eq("rst_tkeep", tkeep_a, 8'h00);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_rd_en", rd_en_a, 0);
        check_eq("rst_stat", stat_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single record, tready high
        tx_en  = 1'b1;
        tready = 1'b1;
        base = cap_n;
        p0 = rd_a;
        c0 = cyc;
        push_a(10'h004, 4'hF, 32'h10EE_7024);
        wait_frames_a(32'd1);
        check_eq("t1_pops", rd_a - p0, 1);
        check_eq("t1_beats", cap_n - base, 2);
        check_eq("t1_b0_data", cap_data[base], 64'h0000_4346_010F_0004);
        check_eq("t1_b0_keep", cap_keep[base], 8'hFF);
        check_eq("t1_b0_last", cap_last[base], 0);
        check_eq("t1_b1_data", cap_data[base+1], 64'h0000_0000_10EE_7024);
        check_eq("t1_b1_keep", cap_keep[base+1], 8'h0F);
        check_eq("t1_b1_last", cap_last[base+1], 1);
        check_eq("t1_latency", cap_cyc[base] - c0, 2);
        check_eq("t1_b1_follow", cap_cyc[base+1] - cap_cyc[base], 1);
        check_eq("t1_busy_idle", busy_a, 0);

        // Backpressure: 7 stalled cycles on beat 0, 3 on beat 1
        tready = 1'b0;
        base = cap_n;
        push_a(10'h3FF, 4'h5, 32'hDEAD_BEEF);
        wait_tvalid_a();
        for (int i = 0; i < 7; i++) begin
            check_eq("bp_b0_valid", tvalid_a, 1);
            check_eq("bp_b0_data", tdata_a, 64'h0001_4346_0105_03FF);
            check_eq("bp_b0_keep", tkeep_a, 8'hFF);
            check_eq("bp_b0_last", tlast_a, 0);
            @(negedge clk);
        end
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_b1_valid", tvalid_a, 1);
            check_eq("bp_b1_data", tdata_a, 64'h0000_0000_DEAD_BEEF);
            check_eq("bp_b1_keep", tkeep_a, 8'h0F);
            check_eq("bp_b1_last", tlast_a, 1);
            @(negedge clk);
        end
        tready = 1'b1;
        @(negedge clk);
        check_eq("bp_valid_drop", tvalid_a, 0);
        check_eq("bp_stat", stat_a, 32'd2);
        @(negedge clk);
        check_eq("bp_beats", cap_n - base, 2);

        // Three back-to-back records
        reset_dut();
        base = cap_n;
        p0 = rd_a;
        push_a(10'h010, 4'h3, 32'hA000_0000);
        push_a(10'h011, 4'h3, 32'hA000_0001);
        push_a(10'h012, 4'h3, 32'hA000_0002);
        wait_frames_a(32'd3);
        check_eq("b2b_pops", rd_a - p0, 3);
        check_eq("b2b_f0", cap_data[base], 64'h0000_4346_0103_0010);
        check_eq("b2b_f1", cap_data[base+2], 64'h0001_4346_0103_0011);
        check_eq("b2b_f2", cap_data[base+4], 64'h0002_4346_0103_0012);
        check_eq("b2b_d2", cap_data[base+5], 64'h0000_0000_A000_0002);
        check_eq("b2b_space01", cap_cyc[base+2] - cap_cyc[base], 5);
        check_eq("b2b_space12", cap_cyc[base+4] - cap_cyc[base+2], 5);

        // Sequence wrap on the SEQ_INIT = FFFE instance
        p0 = capb_n;
        push_b(10'h001, 4'h1, 32'h0000_0001);
        push_b(10'h002, 4'h1, 32'h0000_0002);
        push_b(10'h003, 4'h1, 32'h0000_0003);
        k = 0;
        while (stat_b != 32'd3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_eq("wrap_stat", stat_b, 32'd3);
        check_eq("wrap_s0", capb_seq[p0], 16'hFFFE);
        check_eq("wrap_s1", capb_seq[p0+1], 16'hFFFF);
        check_eq("wrap_s2", capb_seq[p0+2], 16'h0000);

        // tx_en dropped during HDR with two records queued
        reset_dut();
        tready = 1'b0;
        base = cap_n;
        p0 = rd_a;
        push_a(10'h020, 4'hC, 32'h5555_0001);
        push_a(10'h021, 4'h8, 32'h5555_0002);
        wait_tvalid_a();
        tx_en  = 1'b0;
        tready = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("txen_stat", stat_a, 32'd1);
        check_eq("txen_pops", rd_a - p0, 1);
        check_eq("txen_busy", busy_a, 0);
        check_eq("txen_pending", empty_a, 0);
        tx_en = 1'b1;
        wait_frames_a(32'd2);
        check_eq("txen_pops2", rd_a - p0, 2);
        check_eq("txen_f1", cap_data[base+2], 64'h0001_4346_0108_0021);

        // Reset asserted during DAT
        tready = 1'b0;
        push_a(10'h155, 4'h2, 32'h6666_0001);
        push_a(10'h2AA, 4'h6, 32'h6666_0002);
        wait_tvalid_a();
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        @(negedge clk);
        check_eq("dat_last", tlast_a, 1);
        check_eq("dat_busy", busy_a, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_tvalid", tvalid_a, 0);
        check_eq("arst_stat", stat_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = cap_n;
        tready = 1'b1;
        wait_frames_a(32'd1);
        check_eq("arst_f0", cap_data[base], 64'h0000_4346_0106_02AA);
        check_eq("arst_d0", cap_data[base+1], 64'h0000_0000_6666_0002);
        check_eq("arst_drained", rd_a, wr_a);

        check_eq("pop_while_empty", pop_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
